// File: rtl/example_pkg.sv
// Shared constants for the six-input registered Boolean evaluator.
// Latency: n/a (package only).
// Backpressure: n/a; en is the only flow control in this block family.
package example_pkg;

    // Default truth table: (a&~b&d) | (c&d&~e) | (e&f), index {a,b,c,d,e,f}.
    localparam logic [63:0] EXAMPLE_LUT_DEFAULT = 64'hB888_F8F8_B888_B888;
    localparam int          EXAMPLE_MAX_LATENCY = 4;
    localparam int          EXAMPLE_CNT_W       = 16;

endpackage

// File: rtl/example_edge_det.sv
// Registers one-cycle rise/fall pulses from the pipeline output's old and next value.
// Latency: flags appear on the same edge that updates y.
// Backpressure: when en_i=0 both flags clear, so pulses never stretch.
module example_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic en_i,
    input  logic y_old_i,
    input  logic y_new_i,
    output logic y_rise_o,
    output logic y_fall_o
);

    logic rise_q, rise_d;
    logic fall_q, fall_d;

    // Next flag values: only an enabled edge can produce a transition.
    always_comb begin
        rise_d = en_i & ~y_old_i &  y_new_i;
        fall_d = en_i &  y_old_i & ~y_new_i;
    end

    // Flag registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign y_rise_o = rise_q;
    assign y_fall_o = fall_q;

endmodule

// File: rtl/example.sv
// Six-input LUT lookup feeding a LATENCY-deep register pipeline with edge flags on y.
// Latency: LATENCY enabled edges from input sampling to y (1..4).
// Backpressure: en=0 holds every stage; optional toggle_cnt under EXAMPLE_TOGGLE_CNT_EN.
module example
    import example_pkg::*;
#(
    parameter logic [63:0] LUT_INIT = EXAMPLE_LUT_DEFAULT,
    parameter int          LATENCY  = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic a,
    input  logic b,
    input  logic c,
    input  logic d,
    input  logic e,
    input  logic f,
    output logic y,
    output logic y_rise,
    output logic y_fall
`ifdef EXAMPLE_TOGGLE_CNT_EN
    ,
    output logic [EXAMPLE_CNT_W-1:0] toggle_cnt
`endif
);

    if (LATENCY < 1 || LATENCY > EXAMPLE_MAX_LATENCY) begin : g_bad_latency
        $error("example: LATENCY must be in 1..4");
    end

    logic [5:0]         idx;
    logic               lut_v;
    logic [LATENCY-1:0] stage_q, stage_d;

    assign idx   = {a, b, c, d, e, f};
    assign lut_v = LUT_INIT[idx];

    // Shift the lookup result down the pipeline only on enabled edges.
    always_comb begin
        stage_d = stage_q;
        if (en) begin
            stage_d[0] = lut_v;
            for (int i = 1; i < LATENCY; i++) begin
                stage_d[i] = stage_q[i-1];
            end
        end
    end

    // Pipeline registers; reset flushes anything in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign y = stage_q[LATENCY-1];

    // Edge flags compare y before the edge with the value it is about to take.
    example_edge_det u_edge_det (
        .clk      (clk),
        .rst_n    (rst_n),
        .en_i     (en),
        .y_old_i  (stage_q[LATENCY-1]),
        .y_new_i  (stage_d[LATENCY-1]),
        .y_rise_o (y_rise),
        .y_fall_o (y_fall)
    );

`ifdef EXAMPLE_TOGGLE_CNT_EN
    logic [EXAMPLE_CNT_W-1:0] cnt_q, cnt_d;

    // Count flagged cycles one edge later, saturating instead of wrapping.
    always_comb begin
        cnt_d = cnt_q;
        if (en && (y_rise || y_fall) && (cnt_q != {EXAMPLE_CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register, cleared by reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign toggle_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_example.sv
// Bench for example: three instances (LATENCY 1, 3, 4) share stimulus and are
// compared every edge against a history-queue model built from the Boolean equation.
module tb_example;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [5:0] idx;
    logic       a, b, c, d, e, f;
    logic [2:0] y_o, rise_o, fall_o;

    assign {a, b, c, d, e, f} = idx;

    always #5 clk = ~clk;

`ifdef EXAMPLE_TOGGLE_CNT_EN
    logic [15:0] cnt_o [3];
`endif

    example #(.LATENCY(1)) u_dut_l1 (
        .clk(clk), .rst_n(rst_n), .en(en),
        .a(a), .b(b), .c(c), .d(d), .e(e), .f(f),
        .y(y_o[0]), .y_rise(rise_o[0]), .y_fall(fall_o[0])
`ifdef EXAMPLE_TOGGLE_CNT_EN
        , .toggle_cnt(cnt_o[0])
`endif
    );

    example #(.LATENCY(3)) u_dut_l3 (
        .clk(clk), .rst_n(rst_n), .en(en),
        .a(a), .b(b), .c(c), .d(d), .e(e), .f(f),
        .y(y_o[1]), .y_rise(rise_o[1]), .y_fall(fall_o[1])
`ifdef EXAMPLE_TOGGLE_CNT_EN
        , .toggle_cnt(cnt_o[1])
`endif
    );

    example #(.LATENCY(4)) u_dut_l4 (
        .clk(clk), .rst_n(rst_n), .en(en),
        .a(a), .b(b), .c(c), .d(d), .e(e), .f(f),
        .y(y_o[2]), .y_rise(rise_o[2]), .y_fall(fall_o[2])
`ifdef EXAMPLE_TOGGLE_CNT_EN
        , .toggle_cnt(cnt_o[2])
`endif
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int lat_tab [3] = '{1, 3, 4};
    bit hist [$];            // results of enabled edges since reset, newest first
    bit y_m [3];
    bit r_m [3];
    bit f_m [3];
    int cnt_m [3];

    function automatic bit ref_v(input logic [5:0] x);
        bit va, vb, vc, vd, ve, vf;
        {va, vb, vc, vd, ve, vf} = x;
        return (va & ~vb & vd) | (vc & vd & ~ve) | (ve & vf);
    endfunction

    task automatic model_edge();
        bit ynew;
        if (!rst_n) begin
            hist.delete();
            for (int k = 0; k < 3; k++) begin
                y_m[k] = 0; r_m[k] = 0; f_m[k] = 0; cnt_m[k] = 0;
            end
        end else if (en) begin
            hist.push_front(ref_v(idx));
            if (hist.size() > 4) void'(hist.pop_back());
            for (int k = 0; k < 3; k++) begin
                if ((r_m[k] | f_m[k]) && cnt_m[k] < 65535) cnt_m[k]++;
                ynew = (hist.size() >= lat_tab[k]) ? hist[lat_tab[k]-1] : 1'b0;
                r_m[k] = ~y_m[k] & ynew;
                f_m[k] = y_m[k] & ~ynew;
                y_m[k] = ynew;
            end
        end else begin
            for (int k = 0; k < 3; k++) begin
                r_m[k] = 0; f_m[k] = 0;
            end
        end
    endtask

    // One clock edge: advance the model with pre-edge inputs, then compare.
    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("y_l%0d", lat_tab[k]), {31'd0, y_o[k]}, {31'd0, y_m[k]});
            check($sformatf("rise_l%0d", lat_tab[k]), {31'd0, rise_o[k]}, {31'd0, r_m[k]});
            check($sformatf("fall_l%0d", lat_tab[k]), {31'd0, fall_o[k]}, {31'd0, f_m[k]});
`ifdef EXAMPLE_TOGGLE_CNT_EN
            check($sformatf("cnt_l%0d", lat_tab[k]), {16'd0, cnt_o[k]}, cnt_m[k]);
`endif
        end
    endtask

    logic [5:0] vec_idx [5] = '{6'd36, 6'd12, 6'd37, 6'd30, 6'd0};
    bit         vec_y   [5] = '{1, 1, 1, 0, 0};
    bit         vec_f   [5] = '{0, 0, 0, 1, 0};

    initial begin
        rst_n = 1'b0;
        en    = 1'b1;
        idx   = 6'd36;

        // Reset with a 1-producing input held.
        tick(); tick();
        check("rst_y", {31'd0, y_o[0]}, 32'd0);
        check("rst_rise", {31'd0, rise_o[0]}, 32'd0);
        check("rst_fall", {31'd0, fall_o[0]}, 32'd0);

        // Release: first enabled edge compares against y=0.
        rst_n = 1'b1;
        tick();
        check("rel_y", {31'd0, y_o[0]}, 32'd1);
        check("rel_rise", {31'd0, rise_o[0]}, 32'd1);
        tick();
        check("rel_rise_pulse", {31'd0, rise_o[0]}, 32'd0);

        // Truth-table vectors on the LATENCY=1 instance.
        for (int i = 0; i < 5; i++) begin
            idx = vec_idx[i];
            tick();
            check($sformatf("vec%0d_y", i), {31'd0, y_o[0]}, {31'd0, vec_y[i]});
            check($sformatf("vec%0d_fall", i), {31'd0, fall_o[0]}, {31'd0, vec_f[i]});
        end

        // LATENCY=3 step from idx 0 to idx 36.
        idx = 6'd0;
        repeat (4) tick();
        idx = 6'd36;
        for (int n = 1; n <= 3; n++) begin
            tick();
            check($sformatf("lat3_y_e%0d", n), {31'd0, y_o[1]}, (n == 3) ? 32'd1 : 32'd0);
            check($sformatf("lat3_rise_e%0d", n), {31'd0, rise_o[1]}, (n == 3) ? 32'd1 : 32'd0);
        end
        tick();
        check("lat3_rise_once", {31'd0, rise_o[1]}, 32'd0);

        // Enable hold: y stays 1 while inputs drop to idx 0.
        en  = 1'b0;
        idx = 6'd0;
        for (int n = 0; n < 4; n++) begin
            tick();
            check("hold_y", {31'd0, y_o[0]}, 32'd1);
            check("hold_flags", {30'd0, rise_o[0], fall_o[0]}, 32'd0);
        end
        en = 1'b1;
        tick();
        check("unhold_y", {31'd0, y_o[0]}, 32'd0);
        check("unhold_fall", {31'd0, fall_o[0]}, 32'd1);
        repeat (4) tick();

        // Mid-stream reset on LATENCY=4 with a 1 in flight.
        idx = 6'd36;
        tick(); tick();
        idx   = 6'd0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int n = 0; n < 6; n++) begin
            tick();
            check("flush_y_l4", {31'd0, y_o[2]}, 32'd0);
            check("flush_rise_l4", {31'd0, rise_o[2]}, 32'd0);
        end

        // Randomized traffic with random enable and occasional reset.
        for (int n = 0; n < 600; n++) begin
            idx   = 6'($urandom);
            en    = ($urandom_range(0, 3) != 0);
            rst_n = ($urandom_range(0, 49) != 0);
            tick();
        end

`ifdef EXAMPLE_TOGGLE_CNT_EN
        // Toggle counter: 10 alternations, then saturation.
        en    = 1'b1;
        idx   = 6'd0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int n = 0; n < 10; n++) begin
            idx = (n % 2 == 0) ? 6'd36 : 6'd0;
            tick();
        end
        tick();
        check("cnt_ten", {16'd0, cnt_o[0]}, 32'd10);
        for (int n = 0; n < 70000; n++) begin
            idx = (n % 2 == 0) ? 6'd36 : 6'd0;
            tick();
        end
        tick();
        check("cnt_sat", {16'd0, cnt_o[0]}, 32'h0000_FFFF);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/example.md
Name: example

Overview:
- Six-input registered Boolean evaluator: looks up output y for the inputs {a,b,c,d,e,f} in a 64-entry truth table parameter.
- The result passes through a configurable-depth pipeline, with one-cycle edge flags on y.
- Sits as a small control-decode leaf wherever a fixed 6-input condition must be registered and edge-detected.

Parameters:
- LUT_INIT, 64'hB888_F8F8_B888_B888, truth table; bit idx gives y for idx = {a,b,c,d,e,f} (a is MSB). The default equals (a&~b&d) | (c&d&~e) | (e&f).
- LATENCY, 1, number of register stages from input sampling to y; legal range 1..4; other values are a elaboration error.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  synchronous active-low reset
- en  input  1  pipeline advance enable; when 0, all stages and flags hold
- a  input  1  condition input, idx bit 5
- b  input  1  condition input, idx bit 4
- c  input  1  condition input, idx bit 3
- d  input  1  condition input, idx bit 2
- e  input  1  condition input, idx bit 1
- f  input  1  condition input, idx bit 0
- y  output  1  registered result, last pipeline stage
- y_rise  output  1  one-cycle pulse: y went 0->1 at this edge
- y_fall  output  1  one-cycle pulse: y went 1->0 at this edge

Behaviour:
- Reset: clk, rst_n, synchronous active-low, as decided. While rst_n=0 at a rising edge, all pipeline stages, y, y_rise and y_fall become 0. Reset overrides en.
- Lookup: combinational v = LUT_INIT[{a,b,c,d,e,f}]. No X-propagation handling is required beyond normal simulation.
- Pipeline, rising edge with rst_n=1 and en=1:
  - stage[0] <= v
  - stage[i] <= stage[i-1] for i = 1..LATENCY-1
  - y is stage[LATENCY-1]
  - With steady inputs, y reflects them exactly LATENCY enabled edges later.
- en=0: every stage holds and y holds. y_rise and y_fall are cleared to 0 on that edge (pulses never stretch).
- Edge flags, registered on the same edge as y:
  - y_rise <= en & ~y_old & y_new
  - y_fall <= en & y_old & ~y_new
  - y_old is y before the edge and y_new after it. At most one flag is high per cycle.
- Reset release: the first enabled edge after reset compares against y=0, so a 1 result produces y_rise.
- Reset mid-operation: the pipeline is flushed. In-flight results are discarded, not delivered.
- Inputs change freely every cycle. No handshake; en is the only flow control.

Optional Feature:
- Macro: EXAMPLE_TOGGLE_CNT_EN.
- Defined:
  - Adds output toggle_cnt (16 bits): count of cycles with y_rise|y_fall high.
  - Saturates at 16'hFFFF (no wrap).
  - Cleared by reset.
  - Holds when en=0.
  - Increments one edge after the flag.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package example_pkg:
  - EXAMPLE_LUT_DEFAULT (64'hB888_F8F8_B888_B888)
  - EXAMPLE_MAX_LATENCY (4)
  - EXAMPLE_CNT_W (16)
- One natural sub-module, example_edge_det: takes y_old and y_new plus en; registers y_rise and y_fall. The top holds the lookup and the pipeline.

Test Plan:
- Reset: rst_n=0 for 2 edges with a..f = 1,0,0,1,0,0 and en=1 -> y=0, y_rise=0, y_fall=0. Release -> after 1 edge (LATENCY=1), y=1 and y_rise=1 for one cycle.
- Truth-table vectors, LATENCY=1, en=1:
  - (1,0,0,1,0,0) -> y=1
  - (0,0,1,1,0,0) -> y=1
  - (1,0,0,1,0,1) -> y=1
  - (0,1,1,1,1,0) -> y=0, with y_fall pulse
  - (0,0,0,0,0,0) -> y=0, no pulse
- Latency: LATENCY=3; step inputs from idx 0 to idx 36 -> y rises exactly 3 edges later and y_rise pulses once.
- Enable hold: y=1, then en=0 for 4 cycles while inputs go to idx 0 -> y stays 1 with no flags. en=1 -> y=0 after LATENCY edges and y_fall=1.
- Mid-stream reset: LATENCY=4 with a 1 in flight; assert rst_n=0 for 1 edge -> y never shows the flushed 1.
- With EXAMPLE_TOGGLE_CNT_EN: alternate idx 36 and idx 0 for 10 edges -> toggle_cnt=10. Force 70000 toggles -> toggle_cnt=16'hFFFF.
